// File: rtl/dac128s085_rx_if.sv
// Bundles the DAC128S085 serial link pins and the decoded outputs of the receiver.
// slave: the receiver side (samples the link, drives decoded results).
// master: the link driver / monitor side.
interface dac128s085_rx_if #(
    parameter int CNT_W = 16
);
    logic             SYNC;
    logic             SCLK;
    logic             DIN;
    logic [11:0]      dac1;
    logic [11:0]      dac2;
    logic [11:0]      dac3;
    logic [11:0]      dac4;
    logic [11:0]      dac5;
    logic [11:0]      dac6;
    logic [11:0]      dac7;
    logic [11:0]      dac8;
    logic             wr_valid;
    logic [2:0]       wr_ch;
    logic [11:0]      wr_data;
    logic             cmd_valid;
    logic [15:0]      cmd_word;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output SYNC, SCLK, DIN,
        input  dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8,
        input  wr_valid, wr_ch, wr_data, cmd_valid, cmd_word, frame_err, frame_cnt
    );

    modport slave (
        input  SYNC, SCLK, DIN,
        output dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8,
        output wr_valid, wr_ch, wr_data, cmd_valid, cmd_word, frame_err, frame_cnt
    );
endinterface

// File: rtl/dac128s085_rx.sv
// Receive-side decoder for the DAC128S085 SYNC/SCLK/DIN link.
// Oversamples the link on clk, reassembles 16-bit MSB-first frames and keeps a
// shadow copy of the eight channel codes.
// Optional: define DAC_RX_GLITCH_FILTER_EN to add a 3-sample majority filter on
// the synchronized SYNC and SCLK (DIN delayed one stage to stay aligned).
module dac128s085_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dac128s085_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_pipe_q;
    logic [SYNC_STAGES-1:0] sclk_pipe_q;
    logic [SYNC_STAGES-1:0] din_pipe_q;

    logic sync_s;
    logic sclk_s;
    logic din_s;
    logic sclk_prev_q;
    logic sclk_fall;

    state_t           state_q;
    logic [15:0]      sreg_q;
    logic [15:0]      sreg_d;
    logic [4:0]       bit_cnt_q;
    logic             overrun_q;
    logic [11:0]      dac_q [8];
    logic             wr_valid_q;
    logic [2:0]       wr_ch_q;
    logic [11:0]      wr_data_q;
    logic             cmd_valid_q;
    logic [15:0]      cmd_word_q;
    logic             frame_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    // Input synchronizers; SYNC idles high, so its chain resets high to avoid a phantom frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe_q <= '1;
            sclk_pipe_q <= '0;
            din_pipe_q  <= '0;
        end else begin
            sync_pipe_q <= {sync_pipe_q[SYNC_STAGES-2:0], bus.SYNC};
            sclk_pipe_q <= {sclk_pipe_q[SYNC_STAGES-2:0], bus.SCLK};
            din_pipe_q  <= {din_pipe_q[SYNC_STAGES-2:0],  bus.DIN};
        end
    end

`ifdef DAC_RX_GLITCH_FILTER_EN
    logic [1:0] sync_hist_q;
    logic [1:0] sclk_hist_q;
    logic       din_dly_q;

    // Sample history for the majority vote; DIN gets one delay stage to match the vote latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_hist_q <= '1;
            sclk_hist_q <= '0;
            din_dly_q   <= 1'b0;
        end else begin
            sync_hist_q <= {sync_hist_q[0], sync_pipe_q[SYNC_STAGES-1]};
            sclk_hist_q <= {sclk_hist_q[0], sclk_pipe_q[SYNC_STAGES-1]};
            din_dly_q   <= din_pipe_q[SYNC_STAGES-1];
        end
    end

    // 2-of-3 majority rejects single-cycle glitches on SYNC and SCLK.
    always_comb begin
        sync_s = (sync_pipe_q[SYNC_STAGES-1] & sync_hist_q[0]) |
                 (sync_pipe_q[SYNC_STAGES-1] & sync_hist_q[1]) |
                 (sync_hist_q[0] & sync_hist_q[1]);
        sclk_s = (sclk_pipe_q[SYNC_STAGES-1] & sclk_hist_q[0]) |
                 (sclk_pipe_q[SYNC_STAGES-1] & sclk_hist_q[1]) |
                 (sclk_hist_q[0] & sclk_hist_q[1]);
        din_s  = din_dly_q;
    end
`else
    // Synchronizer outputs feed the edge detector directly.
    always_comb begin
        sync_s = sync_pipe_q[SYNC_STAGES-1];
        sclk_s = sclk_pipe_q[SYNC_STAGES-1];
        din_s  = din_pipe_q[SYNC_STAGES-1];
    end
`endif

    // Previous SCLK sample for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
        end
    end

    // SCLK fall strobe and the shift register value it would load.
    always_comb begin
        sclk_fall = sclk_prev_q & ~sclk_s;
        sreg_d    = {sreg_q[14:0], din_s};
    end

    // Frame FSM: collects 16 bits, commits channel writes or commands, flags short/overrun frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                dac_q[i] <= '0;
            end
            wr_valid_q  <= 1'b0;
            wr_ch_q     <= '0;
            wr_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_word_q  <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_valid_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A coincident SCLK fall is deliberately not looked at here.
                    if (!sync_s) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        sreg_q    <= '0;
                        overrun_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    // SYNC rise is tested first so a coincident SCLK fall is not counted.
                    if (sync_s) begin
                        frame_err_q <= 1'b1;
                        sreg_q      <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= IDLE;
                    end else if (sclk_fall) begin
                        sreg_q    <= sreg_d;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            if (sreg_d[15]) begin
                                cmd_word_q  <= sreg_d;
                                cmd_valid_q <= 1'b1;
                            end else begin
                                dac_q[sreg_d[14:12]] <= sreg_d[11:0];
                                wr_ch_q     <= sreg_d[14:12];
                                wr_data_q   <= sreg_d[11:0];
                                wr_valid_q  <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                            end
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (sync_s) begin
                        frame_err_q <= overrun_q;
                        overrun_q   <= 1'b0;
                        state_q     <= IDLE;
                    end else if (sclk_fall) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dac1      = dac_q[0];
    assign bus.dac2      = dac_q[1];
    assign bus.dac3      = dac_q[2];
    assign bus.dac4      = dac_q[3];
    assign bus.dac5      = dac_q[4];
    assign bus.dac6      = dac_q[5];
    assign bus.dac7      = dac_q[6];
    assign bus.dac8      = dac_q[7];
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_ch     = wr_ch_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_word  = cmd_word_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dac128s085_rx.sv
// Scoreboard bench for dac128s085_rx: stimulus pushes predicted events, a
// monitor pops and compares them whenever the receiver pulses an output.
module tb_dac128s085_rx;

    localparam int EV_WR  = 0;
    localparam int EV_CMD = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int          kind;
        logic [2:0]  ch;
        logic [11:0] data;
        logic [15:0] word;
    } ev_t;

    logic clk;
    logic rst_n;

    dac128s085_rx_if #(.CNT_W(16)) bus ();

    dac128s085_rx #(
        .SYNC_STAGES (2),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ev_t         exp_q[$];
    logic [11:0] model_dac [8];
    logic [15:0] model_cnt;
    int          n_checks;
    int          n_fail;
    int          wr_seen;
    int          cmd_seen;
    int          err_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] get_dac(input int i);
        case (i)
            0: return bus.dac1;
            1: return bus.dac2;
            2: return bus.dac3;
            3: return bus.dac4;
            4: return bus.dac5;
            5: return bus.dac6;
            6: return bus.dac7;
            default: return bus.dac8;
        endcase
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) model_dac[i] = '0;
        model_cnt = '0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: every output pulse must match the oldest predicted event.
    initial begin
        ev_t e;
        int  npulse;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                npulse = int'(bus.wr_valid) + int'(bus.cmd_valid) + int'(bus.frame_err);
                if (bus.wr_valid)  wr_seen++;
                if (bus.cmd_valid) cmd_seen++;
                if (bus.frame_err) err_seen++;
                if (npulse != 0) begin
                    check("pulse_count_in_cycle", npulse, 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: wr=%0b cmd=%0b err=%0b, expected none",
                                 bus.wr_valid, bus.cmd_valid, bus.frame_err);
                    end else begin
                        e = exp_q.pop_front();
                        case (e.kind)
                            EV_WR: begin
                                check("wr_valid", bus.wr_valid, 1);
                                check("wr_ch", bus.wr_ch, e.ch);
                                check("wr_data", bus.wr_data, e.data);
                                model_dac[e.ch] = e.data;
                                model_cnt++;
                            end
                            EV_CMD: begin
                                check("cmd_valid", bus.cmd_valid, 1);
                                check("cmd_word", bus.cmd_word, e.word);
                            end
                            default: check("frame_err", bus.frame_err, 1);
                        endcase
                        for (int i = 0; i < 8; i++) check($sformatf("dac%0d_shadow", i + 1), get_dac(i), model_dac[i]);
                        check("frame_cnt", bus.frame_cnt, model_cnt);
                    end
                end
            end
        end
    end

    // Reference prediction: a frame's outcome depends only on its word and number of SCLK falls.
    task automatic predict(input logic [15:0] w, input int nfalls);
        ev_t e;
        e.ch   = w[14:12];
        e.data = w[11:0];
        e.word = w;
        if (nfalls < 16) begin
            e.kind = EV_ERR;
            exp_q.push_back(e);
        end else begin
            e.kind = w[15] ? EV_CMD : EV_WR;
            exp_q.push_back(e);
            if (nfalls > 16) begin
                e.kind = EV_ERR;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int nfalls, input int h, input int glitch_at);
        bus.SYNC = 1'b0;
        clk_wait(h);
        for (int i = 0; i < nfalls; i++) begin
            bus.DIN = (i < 16) ? w[15 - i] : 1'($urandom);
            if (i == glitch_at) begin
                clk_wait(2);
                bus.SCLK = 1'b0;
                clk_wait(1);
                bus.SCLK = 1'b1;
                clk_wait(h);
            end else begin
                clk_wait(h);
            end
            bus.SCLK = 1'b0;
            clk_wait(h);
            bus.SCLK = 1'b1;
        end
        clk_wait(h);
        bus.SYNC = 1'b1;
    endtask

    task automatic do_frame(input logic [15:0] w, input int nfalls, input int h, input int gap);
        predict(w, nfalls);
        send_frame(w, nfalls, h, -1);
        clk_wait(gap);
    endtask

    task automatic drain(input string name);
        clk_wait(12);
        check(name, exp_q.size(), 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          nf;
        int          sel;
        int          wr0;
        int          err0;

        n_checks = 0;
        n_fail   = 0;
        wr_seen  = 0;
        cmd_seen = 0;
        err_seen = 0;
        reset_model();
        bus.SYNC = 1'b1;
        bus.SCLK = 1'b1;
        bus.DIN  = 1'b0;
        rst_n    = 1'b0;
        clk_wait(4);

        // Reset state
        for (int i = 0; i < 8; i++) check($sformatf("rst_dac%0d", i + 1), get_dac(i), 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_ch", bus.wr_ch, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_word", bus.cmd_word, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        rst_n = 1'b1;
        clk_wait(6);
        check("post_reset_no_err", err_seen, 0);

        // Single channel write
        do_frame(16'h3ABC, 16, 3, 4);
        drain("t1_drain");
        check("t1_dac4", bus.dac4, 12'hABC);
        check("t1_wr_ch", bus.wr_ch, 3);
        check("t1_wr_data", bus.wr_data, 12'hABC);
        check("t1_wr_pulses", wr_seen, 1);
        check("t1_frame_cnt", bus.frame_cnt, 1);
        check("t1_dac1", bus.dac1, 0);
        check("t1_dac8", bus.dac8, 0);

        // Back-to-back writes to all channels, 2-clk SYNC-high gaps
        for (int ch = 0; ch < 8; ch++) begin
            w = {1'b0, 3'(ch), 12'((1 << (ch + 1)) - 1)};
            do_frame(w, 16, 3, 2);
        end
        drain("t2_drain");
        for (int i = 0; i < 8; i++) check($sformatf("t2_dac%0d", i + 1), get_dac(i), (1 << (i + 1)) - 1);
        check("t2_frame_cnt", bus.frame_cnt, 9);
        check("t2_no_frame_err", err_seen, 0);

        // Command frame
        wr0 = wr_seen;
        do_frame(16'h9000, 16, 4, 3);
        drain("t3_drain");
        check("t3_cmd_pulses", cmd_seen, 1);
        check("t3_cmd_word", bus.cmd_word, 16'h9000);
        check("t3_no_wr", wr_seen, wr0);
        check("t3_frame_cnt", bus.frame_cnt, 9);
        check("t3_dac1_kept", bus.dac1, 12'h001);

        // Short frame then a full one
        err0 = err_seen;
        wr0  = wr_seen;
        do_frame(16'h4321, 10, 3, 3);
        drain("t4a_drain");
        check("t4_err_pulse", err_seen, err0 + 1);
        check("t4_no_wr", wr_seen, wr0);
        do_frame(16'h1555, 16, 3, 3);
        drain("t4b_drain");
        check("t4_dac2", bus.dac2, 12'h555);

        // Overrun: 18 falls, write commits at bit 16, error on SYNC rise
        err0 = err_seen;
        do_frame(16'h7FFF, 18, 3, 3);
        drain("t5_drain");
        check("t5_dac8", bus.dac8, 12'hFFF);
        check("t5_err_pulse", err_seen, err0 + 1);

        // Reset in the middle of a frame
        w = 16'h2123;
        bus.SYNC = 1'b0;
        clk_wait(3);
        for (int i = 0; i < 8; i++) begin
            bus.DIN = w[15 - i];
            clk_wait(3);
            bus.SCLK = 1'b0;
            clk_wait(3);
            bus.SCLK = 1'b1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_frame_cnt", bus.frame_cnt, 0);
        check("t6_rst_dac2", bus.dac2, 0);
        check("t6_rst_dac4", bus.dac4, 0);
        check("t6_rst_wr_data", bus.wr_data, 0);
        check("t6_rst_cmd_word", bus.cmd_word, 0);
        bus.SYNC = 1'b1;
        bus.SCLK = 1'b1;
        reset_model();
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(6);
        do_frame(16'h2123, 16, 3, 3);
        drain("t6_drain");
        check("t6_dac3", bus.dac3, 12'h123);
        check("t6_frame_cnt", bus.frame_cnt, 1);

`ifdef DAC_RX_GLITCH_FILTER_EN
        // 1-clk SCLK low glitch inside a high phase must not count as a bit
        predict(16'h6A5C, 16);
        send_frame(16'h6A5C, 16, 5, 7);
        clk_wait(4);
        drain("glitch_drain");
        check("glitch_dac7", bus.dac7, 12'hA5C);
`endif

        // Randomized frames: writes, commands, short and overrun frames
        for (int n = 0; n < 40; n++) begin
            w   = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      nf = int'($urandom_range(1, 15));
            else if (sel == 1) nf = int'($urandom_range(17, 20));
            else               nf = 16;
            do_frame(w, nf, int'($urandom_range(3, 5)), int'($urandom_range(2, 5)));
        end
        drain("rand_drain");
        for (int i = 0; i < 8; i++) check($sformatf("rand_dac%0d", i + 1), get_dac(i), model_dac[i]);
        check("rand_frame_cnt", bus.frame_cnt, model_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
